// File: rtl/gray_conv_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin Gray conversion scheduler.
package gray_conv_rr_scheduler_pkg;

   localparam int DEFAULT_WIDTH = 4;
   localparam int DEFAULT_CNT_W = 8;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   localparam logic ID_REQ0 = 1'b0;
   localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/gray_conv_rr_scheduler_if.sv
// Requester, result and grant-counter signals of the Gray conversion scheduler.
interface gray_conv_rr_scheduler_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             req0_valid;
   logic [WIDTH-1:0] req0_bin;
   logic             req0_ready;
   logic             req1_valid;
   logic [WIDTH-1:0] req1_bin;
   logic             req1_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_gray;
   logic             out_id;
   logic             out_ready;
   logic [CNT_W-1:0] gnt_cnt0;
   logic [CNT_W-1:0] gnt_cnt1;

   // Requesters and consumer side.
   modport master (
      output req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
      input  req0_ready, req1_ready, out_valid, out_gray, out_id, gnt_cnt0, gnt_cnt1
   );

   // Scheduler side.
   modport slave (
      input  req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
      output req0_ready, req1_ready, out_valid, out_gray, out_id, gnt_cnt0, gnt_cnt1
   );
endinterface

// File: rtl/gray_conv_rr_scheduler_b2g_core.sv
// Combinational binary-to-Gray converter: each bit is the XOR of itself and its upper neighbour.
module b2g_core #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_conv_rr_scheduler.sv
// Two-requester round-robin front end sharing one binary-to-Gray converter,
// with a one-entry output register and saturating per-requester grant counters.
module gray_conv_rr_scheduler
   import gray_conv_rr_scheduler_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic                             clk,
   input  logic                             rst,
   gray_conv_rr_scheduler_if.slave          bus,
   output state_e                           dbg_state
);

   state_e           state_q, state_d;
   logic             rr_ptr_q;
   logic [WIDTH-1:0] gray_q;
   logic             id_q;
   logic [CNT_W-1:0] cnt0_q, cnt1_q;

   logic             slot_free;
   logic             grant0, grant1;
   logic             accept0, accept1, accept_any;
   logic [WIDTH-1:0] sel_bin, sel_gray;

   // Handshake: a word moves on a clk edge where valid and ready are both high.
   // The requester holds valid/bin until ready; ready depends only on valids,
   // out_ready and registered state, and is forced low while rst is high.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         grant0 = (rr_ptr_q == ID_REQ0);
         grant1 = (rr_ptr_q == ID_REQ1);
      end else begin
         grant0 = bus.req0_valid;
         grant1 = bus.req1_valid;
      end
   end

   assign slot_free  = (state_q == ST_EMPTY) | bus.out_ready;
   assign accept0    = slot_free & grant0 & ~rst;
   assign accept1    = slot_free & grant1 & ~rst;
   assign accept_any = accept0 | accept1;
   assign sel_bin    = accept1 ? bus.req1_bin : bus.req0_bin;

   b2g_core #(.WIDTH(WIDTH)) u_b2g (
      .bin  (sel_bin),
      .gray (sel_gray)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (accept_any) state_d = ST_FULL;
         ST_FULL:  if (bus.out_ready) state_d = accept_any ? ST_FULL : ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_EMPTY;
         rr_ptr_q <= ID_REQ0;
         gray_q   <= '0;
         id_q     <= ID_REQ0;
         cnt0_q   <= '0;
         cnt1_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept_any) begin
            gray_q   <= sel_gray;
            id_q     <= accept1 ? ID_REQ1 : ID_REQ0;
            // The loser of a tie gets priority next time.
            rr_ptr_q <= accept1 ? ID_REQ0 : ID_REQ1;
         end
         if (accept0 && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_W'(1);
         if (accept1 && (cnt1_q != '1)) cnt1_q <= cnt1_q + CNT_W'(1);
      end
   end

   assign bus.req0_ready = accept0;
   assign bus.req1_ready = accept1;
   assign bus.out_valid  = (state_q == ST_FULL);
   assign bus.out_gray   = gray_q;
   assign bus.out_id     = id_q;
   assign bus.gnt_cnt0   = cnt0_q;
   assign bus.gnt_cnt1   = cnt1_q;
   assign dbg_state      = state_q;

endmodule

// File: doc/gray_conv_rr_scheduler.md
Name: gray_conv_rr_scheduler

Overview:
Shares a single binary-to-Gray conversion datapath between two requesters using round-robin arbitration.
Each requester presents a binary word through a valid/ready handshake. The granted word is converted and held in a one-entry output register, tagged with the requester ID, until the downstream consumer takes it.
The block sits between the code-generation sources (counters, position encoders) and the Gray-coded consumers (CDC pointers, display/encoder logic).

Parameters:
WIDTH, 4, bit width of binary input and Gray output
CNT_W, 8, width of per-requester saturating grant counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high; one clock, all state reset on the clk edge with rst=1
req0_valid  in  1  requester 0 has a word
req0_bin  in  WIDTH  requester 0 binary word
req0_ready  out  1  requester 0 word accepted this cycle
req1_valid  in  1  requester 1 has a word
req1_bin  in  WIDTH  requester 1 binary word
req1_ready  out  1  requester 1 word accepted this cycle
out_valid  out  1  out_gray/out_id hold a result
out_gray  out  WIDTH  Gray code of granted word
out_id  out  1  requester that produced out_gray (0/1)
out_ready  in  1  consumer takes the result this cycle
gnt_cnt0  out  CNT_W  saturating count of grants to requester 0
gnt_cnt1  out  CNT_W  saturating count of grants to requester 1

Behaviour:
- Conversion rule: gray[WIDTH-1] = bin[WIDTH-1]; gray[i] = bin[i+1] ^ bin[i] for i < WIDTH-1. Pure XOR, no arithmetic or width growth.
- FSM, 2 states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- slot_free = (state==EMPTY) | out_ready. Arbitration happens only when slot_free=1.
- Grant rules, combinational:
  - Only one requester valid -> that requester is granted.
  - Both valid -> requester at rr_ptr is granted.
  - Neither valid -> no grant.
- reqN_ready = slot_free & grant_N. At most one ready is high per cycle. A ready never goes high without the matching valid.
- On grant, at the clk edge:
  - out_gray <= conv(reqN_bin); out_id <= N; state <= FULL.
  - rr_ptr <= ~N, so the loser of a tie wins next time.
  - gnt_cntN increments and saturates at 2^CNT_W-1.
- FULL & out_ready & no grant -> EMPTY. out_gray/out_id keep their last value; they are don't-care to the consumer.
- FULL & ~out_ready -> hold all outputs stable. Both readys=0 (backpressure).
- FULL & out_ready & grant -> stay FULL with the new result. Back-to-back throughput is 1 word/cycle.
- Latency: accept on edge k -> out_valid=1 with the result visible after edge k. Single-cycle registered latency.
- Requester protocol: once valid is raised, the requester holds valid and bin stable until ready. The block does not check this.
- Reset (rst=1 at edge, including mid-transfer):
  - state=EMPTY, out_valid=0, out_gray=0, out_id=0.
  - rr_ptr=0 (requester 0 wins the first tie), gnt_cnt0=gnt_cnt1=0.
  - Any in-flight result is dropped.
  - While rst=1, req0_ready=req1_ready=0.
- No combinational path from out_ready to out_* data. The only combinational paths are valid/out_ready -> reqN_ready.

Decomposition:
- Shared package:
  - FSM state encoding: ST_EMPTY=1'b0, ST_FULL=1'b1.
  - Requester ID constants: ID_REQ0=1'b0, ID_REQ1=1'b1.
  - Default WIDTH.
- Sub-module b2g_core: combinational, parameter WIDTH, ports bin -> gray. Instantiated once on the granted-mux output.
- Arbiter, FSM, output register and counters live in the top module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all valids 0 -> out_valid=0, out_gray=0000, both readys 0, gnt_cnt0=gnt_cnt1=0.
- Single requester: req0_valid=1, bin=0110, out_ready=1 -> req0_ready=1 that cycle; next cycle out_valid=1, out_gray=0101, out_id=0, gnt_cnt0=1.
- Tie / round robin: both valid continuously (req0 bin=1111, req1 bin=0111), out_ready=1 -> grants alternate 0,1,0,1. Outputs alternate 1000/id0 and 0100/id1.
- Backpressure: result 0011->0010 held with out_ready=0 for 3 cycles while req1 valid -> out_gray stable at 0010, req1_ready=0. On out_ready=1, req1_ready=1 the same cycle.
- Drain without refill: FULL, out_ready=1, no valids -> out_valid=0 next cycle.
- Reset mid-operation: FULL with rr_ptr=1 and gnt_cnt1=5, assert rst -> out_valid=0, counters 0. First tie after reset goes to req0.
- Saturation: CNT_W=2, 5 grants to req0 -> gnt_cnt0 stops at 3.
